cordic_voice_scheduler: RTL and testbench
=========================================

# cordic_voice_scheduler

Time-multiplexes a single iterative `Sinusoid_CORDIC` core among `NUM_VOICES` oscillator voices.

- Once per sample tick from the synth clock divider, the block does the following for each enabled voice, in index order:
  - advances that voice's phase accumulator;
  - folds the phase into the CORDIC convergence range;
  - issues one CORDIC request and collects the result.
- The results are summed into one mixed sample for the downstream AC97 path.
- It sits between the oscillator register interface and the CORDIC core, replacing one-CORDIC-per-voice instantiation.

## Interface
Parameters:
- `NUM_VOICES`, 4: voice count, power of two, 2..16.
- `PHASE_W`, 32: phase/wave width, signed Q16 radians / Q16 amplitude.
- `TIMEOUT`, 64: maximum Sys_clk cycles to wait for `Cor_done`.

Ports:
- `Sys_clk`  in  1  system clock; the only clock.
- `Sch_rst`  in  1  reset, asynchronous, active-high.
- `Sch_ce`  in  1  clock enable; when low, the FSM and all registers hold.
- `Sample_tick`  in  1  one-cycle pulse per audio sample, Sys_clk domain.
- `Inc_we`  in  1  phase-increment write strobe.
- `Inc_addr`  in  log2(NUM_VOICES)  voice index for the write.
- `Inc_data`  in  PHASE_W  signed phase increment; |value| < PI.
- `Voice_en`  in  NUM_VOICES  per-voice enable.
- `Cor_phase`  out  PHASE_W  folded phase to the CORDIC.
- `Cor_start`  out  1  one-cycle request pulse to the CORDIC.
- `Cor_done`  in  1  one-cycle result-valid pulse from the CORDIC.
- `Cor_wave`  in  PHASE_W  signed CORDIC sine result.
- `Mix_out`  out  PHASE_W  signed mixed sample.
- `Mix_valid`  out  1  one-cycle pulse when `Mix_out` updates.
- `Overrun`  out  1  one-cycle pulse when a tick is dropped.
- `Timeout_err`  out  1  sticky flag; cleared only by reset.

## Operation
Constants (Q16):
- PI = 0x0003_243F
- HALF_PI = 0x0001_9220
- TWO_PI = 0x0006_487F

FSM states: IDLE, ADVANCE, FOLD, ISSUE, WAIT, ACCUM, DONE.
- IDLE: on `Sample_tick & Sch_ce`, clear the accumulator, set v = 0, go to ADVANCE.
- ADVANCE, when `Voice_en[v]` = 0: skip the voice (phase held, contributes 0) and go to ACCUM.
- ADVANCE, when `Voice_en[v]` = 1:
  - p = phase[v] + inc[v];
  - if p ≥ PI, subtract TWO_PI; if p < −PI, add TWO_PI;
  - store p in phase[v]; go to FOLD.
- FOLD: compute the folded phase f; sine is preserved, so no output negation is needed.
  - f = PI − p if p > HALF_PI;
  - f = −PI − p if p < −HALF_PI;
  - otherwise f = p.
- ISSUE: drive `Cor_phase` = f and pulse `Cor_start` for one cycle; go to WAIT.
- WAIT:
  - on `Cor_done`, latch `Cor_wave` and go to ACCUM;
  - after TIMEOUT cycles without `Cor_done`, latch 0, set `Timeout_err`, and go to ACCUM.
- ACCUM: add the latched value to the accumulator (width PHASE_W + log2(NUM_VOICES)).
  - if v = NUM_VOICES − 1, go to DONE; otherwise increment v and go to ADVANCE.
- DONE: `Mix_out` = accumulator >>> log2(NUM_VOICES), so no saturation is needed; pulse `Mix_valid`; go to IDLE.

Boundary conditions:
- A `Sample_tick` arriving in any state other than IDLE is dropped and pulses `Overrun`.
- The phase register file is written immediately on `Inc_we` (not gated by the FSM). A write to voice v during a frame takes effect at that voice's next ADVANCE.
- `Voice_en` is sampled in ADVANCE, per voice.
- A `Cor_done` pulse arriving outside WAIT is ignored.
- Reset mid-frame aborts immediately, with no `Mix_valid`.

## Timing
Reset values:
- all phases and increments 0;
- `Mix_out` 0;
- all pulse outputs 0;
- `Cor_phase` 0;
- `Timeout_err` 0;
- FSM in IDLE.

Latency:
- Tick to ADVANCE of voice 0: 1 cycle.
- Enabled voice: 4 cycles + k, where k is the number of WAIT cycles (≥1).
- Disabled voice: 2 cycles (ADVANCE, ACCUM).
- DONE: 1 cycle; `Mix_valid` is asserted during DONE.

Outputs:
- All outputs are registered.
- `Cor_phase` holds its value from ISSUE until the next ISSUE.
- When `Sch_ce` is low, the FSM freezes; the WAIT timeout counter also holds.

## Structure
- Shared package `synth_pkg`:
  - Q16 constants PI, HALF_PI, TWO_PI;
  - the FSM state enum;
  - the phase width.
- Sub-module `phase_wrap_fold`: combinational; takes phase + increment and produces the wrapped phase plus the folded phase. It is reused by future LFO blocks.
- Phase/increment storage uses register arrays indexed by v.

## Test plan
- Reset asserted during WAIT:
  - required: next cycle `Cor_start` = 0, `Mix_valid` = 0, FSM in IDLE;
  - a subsequent tick shows `Cor_phase` = increment (phase restarted from 0).
- Voice 0 only, inc = 0x00B4, `Cor_wave` = 0x1000 after 3 cycles:
  - `Cor_phase` = 0x0000_00B4;
  - `Mix_out` = 0x0000_0400 with one `Mix_valid`.
- Voice 0, inc = 0x0003_0000, two ticks:
  - tick 1: `Cor_phase` = 0x0000_243F;
  - tick 2: `Cor_phase` = 0xFFFF_B781 (wrapped, no fold).
- Tick issued during WAIT:
  - one `Overrun` pulse;
  - exactly one `Mix_valid` for the frame.
- `Cor_done` held low:
  - `Timeout_err` sets after 64 WAIT cycles;
  - `Mix_out` = 0x0 for a single enabled voice.
- `Voice_en` = 0 on all voices:
  - no `Cor_start`;
  - `Mix_valid` 10 cycles after the tick with `Mix_out` = 0.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared synth definitions: Q16 angle constants, phase width and the voice
// scheduler state encoding.
package synth_pkg;

  localparam int SYNTH_PHASE_W = 32;

  localparam logic signed [31:0] PI      = 32'sh0003_243F;
  localparam logic signed [31:0] HALF_PI = 32'sh0001_9220;
  localparam logic signed [31:0] TWO_PI  = 32'sh0006_487F;

  typedef enum logic [2:0] {
    IDLE, ADVANCE, FOLD, ISSUE, WAIT, ACCUM, DONE
  } sch_state_e;

endpackage

// File: rtl/cordic_voice_scheduler_if.sv
// Request/response bus between the voice scheduler and the shared CORDIC core.
interface cordic_voice_scheduler_if #(parameter int PHASE_W = 32);
  logic [PHASE_W-1:0] Cor_phase;
  logic               Cor_start;
  logic               Cor_done;
  logic [PHASE_W-1:0] Cor_wave;

  modport master (output Cor_phase, Cor_start, input Cor_done, Cor_wave);
  modport slave  (input Cor_phase, Cor_start, output Cor_done, Cor_wave);
endinterface

// File: rtl/phase_wrap_fold.sv
// Combinational phase step: wraps phase+inc into [-PI, PI) and folds the
// result into [-PI/2, PI/2] with sine preserved.
module phase_wrap_fold
  import synth_pkg::*;
#(
  parameter int W = SYNTH_PHASE_W
) (
  input  logic signed [W-1:0] phase,
  input  logic signed [W-1:0] inc,
  output logic signed [W-1:0] wrapped,
  output logic signed [W-1:0] folded
);

  localparam logic signed [W:0]   PI_X     = (W+1)'(PI);
  localparam logic signed [W:0]   TWO_PI_X = (W+1)'(TWO_PI);
  localparam logic signed [W-1:0] PI_W     = W'(PI);
  localparam logic signed [W-1:0] HALF_W   = W'(HALF_PI);

  logic signed [W:0] sum, wrap_x;

  // One extra bit keeps phase+inc exact before the wrap decision.
  always_comb begin
    sum    = $signed({phase[W-1], phase}) + $signed({inc[W-1], inc});
    wrap_x = sum;
    if (sum >= PI_X)       wrap_x = sum - TWO_PI_X;
    else if (sum < -PI_X)  wrap_x = sum + TWO_PI_X;
    wrapped = wrap_x[W-1:0];

    folded = wrapped;
    if (wrapped > HALF_W)        folded = PI_W - wrapped;
    else if (wrapped < -HALF_W)  folded = -PI_W - wrapped;
  end

endmodule

// File: rtl/cordic_voice_scheduler.sv
// Shares one iterative CORDIC among NUM_VOICES oscillators: per sample tick,
// steps each enabled voice's phase, requests its sine and mixes the results.
module cordic_voice_scheduler
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = SYNTH_PHASE_W,
  parameter int TIMEOUT    = 64
) (
  input  logic                          Sys_clk,
  input  logic                          Sch_rst,
  input  logic                          Sch_ce,
  input  logic                          Sample_tick,
  input  logic                          Inc_we,
  input  logic [$clog2(NUM_VOICES)-1:0] Inc_addr,
  input  logic [PHASE_W-1:0]            Inc_data,
  input  logic [NUM_VOICES-1:0]         Voice_en,
  cordic_voice_scheduler_if.master      cor,
  output logic [PHASE_W-1:0]            Mix_out,
  output logic                          Mix_valid,
  output logic                          Overrun,
  output logic                          Timeout_err
);

  localparam int VW = $clog2(NUM_VOICES);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = PHASE_W + VW;

  sch_state_e                 state;
  logic        [VW-1:0]       v;
  logic        [TW-1:0]       wait_cnt;
  logic signed [PHASE_W-1:0]  phase_q [NUM_VOICES];
  logic signed [PHASE_W-1:0]  inc_q   [NUM_VOICES];
  logic signed [PHASE_W-1:0]  fold_q, wave_q;
  logic signed [AW-1:0]       acc, acc_avg;
  logic signed [PHASE_W-1:0]  step_inc, wrapped, folded;

  // In FOLD the stored phase is re-fed with zero increment, so the folder sees
  // the already-wrapped phase and the add and fold land in separate cycles.
  assign step_inc = (state == ADVANCE) ? inc_q[v] : '0;
  assign acc_avg  = acc >>> VW;

  phase_wrap_fold #(.W(PHASE_W)) u_wrap_fold (
    .phase   (phase_q[v]),
    .inc     (step_inc),
    .wrapped (wrapped),
    .folded  (folded)
  );

  always_ff @(posedge Sys_clk or posedge Sch_rst) begin
    if (Sch_rst) begin
      for (int i = 0; i < NUM_VOICES; i++) inc_q[i] <= '0;
    end else if (Sch_ce && Inc_we) begin
      inc_q[Inc_addr] <= Inc_data;
    end
  end

  always_ff @(posedge Sys_clk or posedge Sch_rst) begin
    if (Sch_rst) begin
      state         <= IDLE;
      v             <= '0;
      wait_cnt      <= '0;
      fold_q        <= '0;
      wave_q        <= '0;
      acc           <= '0;
      cor.Cor_phase <= '0;
      cor.Cor_start <= 1'b0;
      Mix_out       <= '0;
      Mix_valid     <= 1'b0;
      Overrun       <= 1'b0;
      Timeout_err   <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
    end else begin
      cor.Cor_start <= 1'b0;
      Mix_valid     <= 1'b0;
      Overrun       <= 1'b0;
      if (Sch_ce) begin
        if (Sample_tick && state != IDLE) Overrun <= 1'b1;
        case (state)
          IDLE: if (Sample_tick) begin
            acc   <= '0;
            v     <= '0;
            state <= ADVANCE;
          end
          ADVANCE: if (Voice_en[v]) begin
            phase_q[v] <= wrapped;
            state      <= FOLD;
          end else begin
            wave_q <= '0;
            state  <= ACCUM;
          end
          FOLD: begin
            fold_q <= folded;
            state  <= ISSUE;
          end
          ISSUE: begin
            cor.Cor_phase <= fold_q;
            cor.Cor_start <= 1'b1;
            wait_cnt      <= '0;
            state         <= WAIT;
          end
          WAIT: if (cor.Cor_done) begin
            wave_q <= cor.Cor_wave;
            state  <= ACCUM;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            wave_q      <= '0;
            Timeout_err <= 1'b1;
            state       <= ACCUM;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          ACCUM: begin
            acc <= acc + $signed({{VW{wave_q[PHASE_W-1]}}, wave_q});
            if (v == VW'(NUM_VOICES - 1)) state <= DONE;
            else begin
              v     <= v + 1'b1;
              state <= ADVANCE;
            end
          end
          DONE: begin
            Mix_out   <= acc_avg[PHASE_W-1:0];
            Mix_valid <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cordic_voice_scheduler.sv
// Directed bench for cordic_voice_scheduler with a CORDIC responder model and
// a scoreboard of expected Cor_phase requests and mixed samples.
module tb_cordic_voice_scheduler;
  import synth_pkg::*;

  logic        Sys_clk = 1'b0;
  logic        Sch_rst, Sch_ce, Sample_tick, Inc_we;
  logic [1:0]  Inc_addr;
  logic [31:0] Inc_data, Mix_out;
  logic [3:0]  Voice_en;
  logic        Mix_valid, Overrun, Timeout_err;

  cordic_voice_scheduler_if #(.PHASE_W(32)) cor ();

  cordic_voice_scheduler #(.NUM_VOICES(4), .PHASE_W(32), .TIMEOUT(64)) dut (
    .Sys_clk     (Sys_clk),
    .Sch_rst     (Sch_rst),
    .Sch_ce      (Sch_ce),
    .Sample_tick (Sample_tick),
    .Inc_we      (Inc_we),
    .Inc_addr    (Inc_addr),
    .Inc_data    (Inc_data),
    .Voice_en    (Voice_en),
    .cor         (cor),
    .Mix_out     (Mix_out),
    .Mix_valid   (Mix_valid),
    .Overrun     (Overrun),
    .Timeout_err (Timeout_err)
  );

  always #5 Sys_clk = ~Sys_clk;

  int          n_checks = 0, n_pass = 0;
  int          n_start = 0, n_mix = 0, n_over = 0;
  logic [31:0] exp_cor[$], exp_mix[$];
  int          resp_delay = 3, resp_cnt = 0;
  bit          resp_en = 1'b1;
  logic [31:0] resp_wave = '0;
  int          s0, m0, o0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Sys_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    Sch_rst = 1'b1;
    cyc(2);
    Sch_rst = 1'b0;
    cyc(1);
  endtask

  task automatic write_inc(input logic [1:0] a, input logic [31:0] d);
    Inc_we = 1'b1; Inc_addr = a; Inc_data = d;
    cyc(1);
    Inc_we = 1'b0;
  endtask

  task automatic tick();
    Sample_tick = 1'b1;
    cyc(1);
    Sample_tick = 1'b0;
  endtask

  task automatic wait_mix(input int target, input string tag);
    for (int i = 0; i < 500 && n_mix < target; i++) cyc(1);
    chk({tag, "_mix_seen"}, 32'(n_mix), 32'(target));
  endtask

  task automatic wait_start(input string tag);
    int i;
    for (i = 0; i < 50; i++) begin
      cyc(1);
      if (cor.Cor_start === 1'b1) break;
    end
    chk({tag, "_start_seen"}, 32'(cor.Cor_start), 32'd1);
  endtask

  // Scoreboard consumers: every request and every mixed sample must match
  // the next queued expectation.
  always @(negedge Sys_clk) begin
    if (cor.Cor_start === 1'b1) begin
      n_start++;
      chk("cor_q_nonempty", 32'(exp_cor.size() > 0), 32'd1);
      if (exp_cor.size() > 0) chk("cor_phase", cor.Cor_phase, exp_cor.pop_front());
    end
    if (Mix_valid === 1'b1) begin
      n_mix++;
      chk("mix_q_nonempty", 32'(exp_mix.size() > 0), 32'd1);
      if (exp_mix.size() > 0) chk("mix_out", Mix_out, exp_mix.pop_front());
    end
    if (Overrun === 1'b1) n_over++;
  end

  // CORDIC model: answers resp_delay cycles after each request when enabled.
  initial begin
    cor.Cor_done = 1'b0;
    cor.Cor_wave = '0;
    forever begin
      @(posedge Sys_clk);
      #1;
      cor.Cor_done = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          cor.Cor_done = 1'b1;
          cor.Cor_wave = resp_wave;
        end
      end
      if (cor.Cor_start === 1'b1 && resp_en) resp_cnt = resp_delay;
    end
  end

  initial begin
    Sch_rst = 1'b1; Sch_ce = 1'b1; Sample_tick = 1'b0; Inc_we = 1'b0;
    Inc_addr = '0; Inc_data = '0; Voice_en = '0;
    cyc(2);
    chk("rst_mix_out", Mix_out, 32'h0);
    chk("rst_cor_phase", cor.Cor_phase, 32'h0);
    chk("rst_cor_start", 32'(cor.Cor_start), 32'd0);
    chk("rst_mix_valid", 32'(Mix_valid), 32'd0);
    chk("rst_overrun", 32'(Overrun), 32'd0);
    chk("rst_timeout", 32'(Timeout_err), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    Sch_rst = 1'b0;
    cyc(1);

    // Single voice, small increment, response after 3 cycles.
    Voice_en = 4'b0001;
    write_inc(2'd0, 32'h0000_00B4);
    resp_wave = 32'h0000_1000; resp_delay = 3;
    exp_cor.push_back(32'h0000_00B4); exp_mix.push_back(32'h0000_0400);
    tick();
    wait_mix(1, "single");
    cyc(5);
    chk("single_one_mix", 32'(n_mix), 32'd1);

    // Wrap/fold boundary over two ticks.
    do_reset();
    write_inc(2'd0, 32'h0003_0000);
    resp_wave = 32'h0000_2000;
    exp_cor.push_back(32'h0000_243F); exp_mix.push_back(32'h0000_0800);
    tick();
    wait_mix(2, "wrap1");
    resp_wave = 32'hFFFF_C000;
    exp_cor.push_back(32'hFFFF_B781); exp_mix.push_back(32'hFFFF_F000);
    tick();
    wait_mix(3, "wrap2");

    // Three voices across fold regions, one disabled.
    do_reset();
    Voice_en = 4'b0111;
    write_inc(2'd0, 32'h0000_00B4);
    write_inc(2'd1, 32'h0002_0000);
    write_inc(2'd2, 32'hFFFE_0000);
    write_inc(2'd3, 32'h0001_2345);
    resp_wave = 32'h0000_4000;
    exp_cor.push_back(32'h0000_00B4);
    exp_cor.push_back(32'h0001_243F);
    exp_cor.push_back(32'hFFFE_DBC1);
    exp_mix.push_back(32'h0000_3000);
    s0 = n_start;
    tick();
    wait_mix(4, "multi");
    chk("multi_starts", 32'(n_start - s0), 32'd3);

    // Tick during WAIT is dropped with one Overrun.
    do_reset();
    Voice_en = 4'b0001;
    write_inc(2'd0, 32'h0000_0100);
    resp_delay = 10; resp_wave = 32'h0000_1000;
    exp_cor.push_back(32'h0000_0100); exp_mix.push_back(32'h0000_0400);
    o0 = n_over; m0 = n_mix;
    tick();
    wait_start("ovr");
    tick();
    chk("ovr_pulse", 32'(Overrun), 32'd1);
    wait_mix(m0 + 1, "ovr");
    cyc(20);
    chk("ovr_count", 32'(n_over - o0), 32'd1);
    chk("ovr_one_mix", 32'(n_mix - m0), 32'd1);

    // CORDIC never answers.
    do_reset();
    write_inc(2'd0, 32'h0000_0200);
    resp_en = 1'b0;
    exp_cor.push_back(32'h0000_0200); exp_mix.push_back(32'h0000_0000);
    m0 = n_mix;
    tick();
    wait_start("tmo");
    cyc(63);
    chk("tmo_not_yet", 32'(Timeout_err), 32'd0);
    cyc(1);
    chk("tmo_set", 32'(Timeout_err), 32'd1);
    wait_mix(m0 + 1, "tmo");
    cyc(3);
    chk("tmo_sticky", 32'(Timeout_err), 32'd1);
    resp_en = 1'b1;

    // All voices disabled: mix lands 10 cycles after the tick.
    Voice_en = 4'b0000;
    s0 = n_start;
    exp_mix.push_back(32'h0000_0000);
    tick();
    cyc(8);
    chk("dis_mix_early", 32'(Mix_valid), 32'd0);
    cyc(1);
    chk("dis_mix_valid", 32'(Mix_valid), 32'd1);
    chk("dis_mix_out", Mix_out, 32'h0);
    cyc(2);
    chk("dis_no_start", 32'(n_start - s0), 32'd0);

    // Reset while waiting on the CORDIC aborts the frame.
    do_reset();
    Voice_en = 4'b0001;
    write_inc(2'd0, 32'h0000_0300);
    resp_delay = 20;
    exp_cor.push_back(32'h0000_0300);
    m0 = n_mix;
    tick();
    wait_start("rst");
    cyc(2);
    Sch_rst = 1'b1;
    cyc(1);
    chk("rstw_cor_start", 32'(cor.Cor_start), 32'd0);
    chk("rstw_mix_valid", 32'(Mix_valid), 32'd0);
    chk("rstw_state", 32'(dut.state), 32'(IDLE));
    Sch_rst = 1'b0;
    cyc(25);
    chk("rstw_no_mix", 32'(n_mix - m0), 32'd0);
    write_inc(2'd0, 32'h0000_0300);
    resp_delay = 3; resp_wave = 32'h0000_1000;
    exp_cor.push_back(32'h0000_0300); exp_mix.push_back(32'h0000_0400);
    tick();
    wait_mix(m0 + 1, "rst_restart");

    cyc(3);
    chk("cor_q_empty", 32'(exp_cor.size()), 32'd0);
    chk("mix_q_empty", 32'(exp_mix.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
